// File: rtl/vfd_pkg.sv
// Shared types and defaults for the VFD scan capture path (Scramble pinout).
// Optional phosphor persistence is enabled with the VFD_DECAY_EN macro in vfd_scan_capture.
package vfd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } vfd_state_e;

    localparam int VFD_GRIDS = 16;
    localparam int VFD_SEGS  = 11;

    // Never returns less than 1 so single-entry configurations still get a legal index width.
    function automatic int vfd_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vfd_onehot_enc.sv
// One-hot to binary index encoder with a strict exactly-one-bit-set flag.
// Shared by the VFD scan capture and the input matrix scanner.
module vfd_onehot_enc
    import vfd_pkg::*;
#(
    parameter int N  = VFD_GRIDS,
    parameter int IW = vfd_clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          onehot_ok
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = idx | IW'(i);
        end
        onehot_ok = (vec != '0) && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/vfd_scan_capture.sv
// Rebuilds a static per-grid segment frame from the multiplexed VFD drive, debouncing
// nibble-wise port rewrites. Define VFD_DECAY_EN to emulate phosphor persistence (DECAY).
module vfd_scan_capture
    import vfd_pkg::*;
#(
    parameter int GRIDS  = VFD_GRIDS,
    parameter int SEGS   = VFD_SEGS,
`ifdef VFD_DECAY_EN
    parameter int DECAY  = 2000,
`endif
    parameter int STABLE = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        smp_en,
    input  logic [GRIDS-1:0]            grid_i,
    input  logic [SEGS-1:0]             seg_i,
    input  logic [vfd_clog2(GRIDS)-1:0] rd_addr,
    output logic [SEGS-1:0]             rd_seg,
    output logic                        frame_done,
    output logic [GRIDS-1:0]            active
);

    localparam int IW = vfd_clog2(GRIDS);

    vfd_state_e             state;
    logic [3:0]             stab_cnt;
    logic [3:0]             next_cnt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          last_idx;
    logic                   onehot_ok;
    logic                   same;
    logic                   commit;
    logic [GRIDS+SEGS-1:0]  sample;
    logic [GRIDS+SEGS-1:0]  smp_q;
    logic [SEGS-1:0]        frame [GRIDS];

    assign sample = {grid_i, seg_i};

    vfd_onehot_enc #(.N(GRIDS), .IW(IW)) u_enc (
        .vec       (grid_i),
        .idx       (idx),
        .onehot_ok (onehot_ok)
    );

    // The sample that completes the stable run is the one committed, so the write
    // lands on the tick that enters COMMIT rather than one tick later.
    always_comb begin
        same     = (sample == smp_q);
        next_cnt = same ? stab_cnt + 4'd1 : 4'd0;
        commit   = smp_en && onehot_ok && (state == SETTLE) && (next_cnt >= 4'(STABLE - 1));
    end

    always_ff @(posedge clk) begin
        if (smp_en) smp_q <= sample;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            stab_cnt   <= '0;
            last_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (smp_en) begin
                if (!onehot_ok) begin
                    state    <= IDLE;
                    stab_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            state    <= SETTLE;
                            stab_cnt <= '0;
                        end
                        SETTLE: begin
                            if (commit) begin
                                state      <= COMMIT;
                                stab_cnt   <= '0;
                                frame_done <= (idx < last_idx);
                                last_idx   <= idx;
                            end else begin
                                stab_cnt <= next_cnt;
                            end
                        end
                        COMMIT, HOLD: begin
                            if (same) begin
                                state <= HOLD;
                            end else begin
                                state    <= SETTLE;
                                stab_cnt <= '0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef VFD_DECAY_EN
    localparam int LW = vfd_clog2(DECAY + 1);
    logic [LW-1:0] life [GRIDS];

    // A commit reloads the life counter, which also masks an expiry in the same tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < GRIDS; g++) begin
                frame[g] <= '0;
                life[g]  <= '0;
            end
            active <= '0;
        end else if (smp_en) begin
            for (int g = 0; g < GRIDS; g++) begin
                if (commit && (idx == IW'(g))) begin
                    frame[g]  <= seg_i;
                    active[g] <= 1'b1;
                    life[g]   <= LW'(DECAY);
                end else if (life[g] != '0) begin
                    life[g] <= life[g] - LW'(1);
                    if (life[g] == LW'(1)) begin
                        frame[g]  <= '0;
                        active[g] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < GRIDS; g++) frame[g] <= '0;
            active <= '0;
        end else if (commit) begin
            frame[idx]  <= seg_i;
            active[idx] <= 1'b1;
        end
    end
`endif

    // Video-side read runs every clk; it sees the pre-commit word on a same-index collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_seg <= '0;
        end else if (int'(rd_addr) < GRIDS) begin
            rd_seg <= frame[rd_addr];
        end else begin
            rd_seg <= '0;
        end
    end

endmodule

// File: tb/tb_vfd_scan_capture.sv
// Directed self-checking bench for vfd_scan_capture in its default build (16 grids, 11 segs, STABLE=3).
module tb_vfd_scan_capture;

    logic        clk;
    logic        reset;
    logic        smp_en;
    logic [15:0] grid_i;
    logic [10:0] seg_i;
    logic [3:0]  rd_addr;
    logic [10:0] rd_seg;
    logic        frame_done;
    logic [15:0] active;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    logic        fd_cap;
    logic [10:0] rd_cap;

    vfd_scan_capture dut (
        .clk        (clk),
        .reset      (reset),
        .smp_en     (smp_en),
        .grid_i     (grid_i),
        .seg_i      (seg_i),
        .rd_addr    (rd_addr),
        .rd_seg     (rd_seg),
        .frame_done (frame_done),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
    end

    // One smp_en tick followed by one idle clk; frame_done and rd_seg are captured right after the tick edge.
    task automatic tick(input logic [15:0] g, input logic [10:0] s);
        grid_i = g;
        seg_i  = s;
        smp_en = 1'b1;
        @(posedge clk);
        #1;
        fd_cap = frame_done;
        rd_cap = rd_seg;
        smp_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic read_frame(input logic [3:0] a, output logic [10:0] v);
        rd_addr = a;
        @(posedge clk);
        #1;
        v = rd_seg;
    endtask

    task automatic test_reset;
        logic [10:0] v;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_seg !== 11'h000 || frame_done !== 1'b0 || active !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: rd_seg=%h frame_done=%b active=%h, want 000/0/0000", rd_seg, frame_done, active);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        read_frame(4'd9, v);
        checks++;
        if (v !== 11'h000) begin
            errors++;
            $display("FAIL reset_frame9: got %h want 000", v);
        end
    endtask

    task automatic test_basic;
        logic [10:0] v;
        tick(16'h0001, 11'h155);
        tick(16'h0001, 11'h155);
        checks++;
        if (active !== 16'h0000) begin
            errors++;
            $display("FAIL basic_early: active=%h want 0000", active);
        end
        tick(16'h0001, 11'h155);
        checks++;
        if (active !== 16'h0001 || fd_cap !== 1'b0) begin
            errors++;
            $display("FAIL basic_commit: active=%h fd=%b want 0001/0", active, fd_cap);
        end
        read_frame(4'd0, v);
        checks++;
        if (v !== 11'h155) begin
            errors++;
            $display("FAIL basic_read: got %h want 155", v);
        end
    endtask

    task automatic test_debounce;
        logic [10:0] v;
        for (int k = 0; k < 10; k++) tick(16'h0004, (k % 2 == 0) ? 11'h00F : 11'h0F0);
        read_frame(4'd2, v);
        checks++;
        if (v !== 11'h000 || active !== 16'h0001) begin
            errors++;
            $display("FAIL debounce_toggle: frame2=%h active=%h want 000/0001", v, active);
        end
        tick(16'h0004, 11'h00F);
        tick(16'h0004, 11'h00F);
        checks++;
        if (active !== 16'h0001) begin
            errors++;
            $display("FAIL debounce_two: active=%h want 0001", active);
        end
        tick(16'h0004, 11'h00F);
        checks++;
        if (active !== 16'h0005 || fd_cap !== 1'b0) begin
            errors++;
            $display("FAIL debounce_commit: active=%h fd=%b want 0005/0", active, fd_cap);
        end
        read_frame(4'd2, v);
        checks++;
        if (v !== 11'h00F) begin
            errors++;
            $display("FAIL debounce_read: got %h want 00F", v);
        end
    endtask

    task automatic test_multi_hot;
        logic [10:0] v;
        for (int k = 0; k < 10; k++) tick(16'h0003, 11'h7FF);
        for (int k = 0; k < 4; k++) tick(16'h0000, 11'h7FF);
        read_frame(4'd1, v);
        checks++;
        if (v !== 11'h000 || active !== 16'h0005) begin
            errors++;
            $display("FAIL multi_hot: frame1=%h active=%h want 000/0005", v, active);
        end
        read_frame(4'd0, v);
        checks++;
        if (v !== 11'h155) begin
            errors++;
            $display("FAIL multi_hot_frame0: got %h want 155", v);
        end
    endtask

    task automatic test_scan_wrap;
        logic [10:0] v;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        fd_cnt = 0;
        for (int g = 0; g < 16; g++) begin
            for (int t = 0; t < 3; t++) tick(16'h0001 << g, 11'h400 | 11'(g));
            if (g == 0) begin
                checks++;
                if (fd_cap !== 1'b0 || active !== 16'h0001) begin
                    errors++;
                    $display("FAIL wrap_first_g0: fd=%b active=%h want 0/0001", fd_cap, active);
                end
            end
        end
        checks++;
        if (fd_cnt !== 0 || active !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ascend: pulses=%0d active=%h want 0/FFFF", fd_cnt, active);
        end
        read_frame(4'd7, v);
        checks++;
        if (v !== 11'h407) begin
            errors++;
            $display("FAIL wrap_frame7: got %h want 407", v);
        end
        for (int t = 0; t < 3; t++) tick(16'h0001, 11'h2AA);
        checks++;
        if (fd_cap !== 1'b1 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL wrap_pulse: fd=%b pulses=%0d want 1/1", fd_cap, fd_cnt);
        end
        for (int t = 0; t < 3; t++) tick(16'h0001, 11'h055);
        read_frame(4'd0, v);
        checks++;
        if (v !== 11'h055 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL same_grid_rewrite: frame0=%h pulses=%0d want 055/1", v, fd_cnt);
        end
        // Collision: read index 5 while grid 5 commits a new word.
        rd_addr = 4'd5;
        for (int t = 0; t < 3; t++) tick(16'h0020, 11'h3C3);
        checks++;
        if (rd_cap !== 11'h405) begin
            errors++;
            $display("FAIL read_before_write: got %h want 405", rd_cap);
        end
        checks++;
        if (rd_seg !== 11'h3C3 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL read_after_write: got %h pulses=%0d want 3C3/1", rd_seg, fd_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] v;
        tick(16'h0008, 11'h001);
        tick(16'h0008, 11'h001);
        @(negedge clk);
        reset = 1'b1;
        #2;
        checks++;
        if (active !== 16'h0000 || rd_seg !== 11'h000 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: active=%h rd_seg=%h fd=%b want 0000/000/0", active, rd_seg, frame_done);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        fd_cnt = 0;
        tick(16'h0008, 11'h001);
        tick(16'h0008, 11'h001);
        checks++;
        if (active !== 16'h0000) begin
            errors++;
            $display("FAIL reset_no_early_commit: active=%h want 0000", active);
        end
        tick(16'h0008, 11'h001);
        checks++;
        if (active !== 16'h0008 || fd_cnt !== 0) begin
            errors++;
            $display("FAIL reset_recommit: active=%h pulses=%0d want 0008/0", active, fd_cnt);
        end
        read_frame(4'd5, v);
        checks++;
        if (v !== 11'h000) begin
            errors++;
            $display("FAIL reset_frame5: got %h want 000", v);
        end
    endtask

    initial begin
        reset   = 1'b1;
        smp_en  = 1'b0;
        grid_i  = '0;
        seg_i   = '0;
        rd_addr = '0;
        test_reset();
        test_basic();
        test_debounce();
        test_multi_hot();
        test_scan_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
